// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, holding register, default depth.
// Pure declarations; no timing or backpressure of its own.
package dmem_arb_pkg;

   localparam int DMEM_WORDS_DEF = 1024;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // addr holds the word index, already shifted down from the byte address
   typedef struct packed {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
   } hold_t;

   function automatic logic addr_illegal(input logic [31:0] byte_addr, input int words);
      logic [31:0] w_limit;
      w_limit = 32'(4 * words);
      return (byte_addr[1:0] != 2'b00) || (byte_addr >= w_limit);
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way combinational grant; DMEM_ARB_RR_EN selects round-robin, otherwise port 0 has fixed priority.
// Zero latency; grant is only ever given to a port whose valid is high.
module rr_arb2 (
   input  logic i_vld0,
   input  logic i_vld1,
   input  logic i_last_grant,
   output logic o_gnt0,
   output logic o_gnt1
);

   logic w_pick1;

`ifdef DMEM_ARB_RR_EN
   // on contention the port that did not win last time goes next
   assign w_pick1 = i_vld1 && (!i_vld0 || !i_last_grant);
`else
   logic w_unused_last_grant;
   assign w_unused_last_grant = i_last_grant;
   assign w_pick1 = i_vld1 && !i_vld0;
`endif

   assign o_gnt1 = w_pick1;
   assign o_gnt0 = i_vld0 && !w_pick1;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port sequencer for the shared data memory; DMEM_ARB_RR_EN enables round-robin arbitration.
// Handshake at edge N, memory access in cycle N+1, response pulse in N+2; one request per 2 cycles.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req_valid,
   output logic        p0_req_ready,
   input  logic        p0_req_we,
   input  logic [31:0] p0_req_addr,
   input  logic [31:0] p0_req_wdata,
   output logic        p0_rsp_valid,
   output logic [31:0] p0_rsp_rdata,
   output logic        p0_rsp_err,
   input  logic        p1_req_valid,
   output logic        p1_req_ready,
   input  logic        p1_req_we,
   input  logic [31:0] p1_req_addr,
   input  logic [31:0] p1_req_wdata,
   output logic        p1_rsp_valid,
   output logic [31:0] p1_rsp_rdata,
   output logic        p1_rsp_err,
   output logic        mem_wr_en,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   state_t      r_state;
   state_t      w_state_nxt;
   hold_t       r_hold;
   hold_t       w_hold_nxt;
   logic        r_last_grant;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_hs;
   logic [31:0] w_sel_addr;
   logic [31:0] w_rsp_rdata;

   logic        r_p0_rsp_vld;
   logic        r_p0_rsp_err;
   logic [31:0] r_p0_rsp_rdata;
   logic        r_p1_rsp_vld;
   logic        r_p1_rsp_err;
   logic [31:0] r_p1_rsp_rdata;

   rr_arb2 u_rr_arb2 (
      .i_vld0       (p0_req_valid),
      .i_vld1       (p1_req_valid),
      .i_last_grant (r_last_grant),
      .o_gnt0       (w_gnt0),
      .o_gnt1       (w_gnt1)
   );

   assign w_hs = p0_req_ready | p1_req_ready;

   always_comb begin
      w_sel_addr       = w_gnt1 ? p1_req_addr : p0_req_addr;
      w_hold_nxt       = '0;
      w_hold_nxt.port  = w_gnt1;
      w_hold_nxt.we    = w_gnt1 ? p1_req_we : p0_req_we;
      w_hold_nxt.addr  = {2'b00, w_sel_addr[31:2]};
      w_hold_nxt.wdata = w_gnt1 ? p1_req_wdata : p0_req_wdata;
      w_hold_nxt.err   = addr_illegal(w_sel_addr, DMEM_WORDS);
   end

   // state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_hs) w_state_nxt = ACCESS;
         ACCESS:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // outputs; reset low blocks grants and memory strobes in the same cycle
   always_comb begin
      p0_req_ready = 1'b0;
      p1_req_ready = 1'b0;
      mem_wr_en    = 1'b0;
      mem_rd_en    = 1'b0;
      if (reset) begin
         case (r_state)
            IDLE: begin
               p0_req_ready = w_gnt0;
               p1_req_ready = w_gnt1;
            end
            ACCESS: begin
               mem_wr_en = r_hold.we && !r_hold.err;
               mem_rd_en = !r_hold.we && !r_hold.err;
            end
            default: ;
         endcase
      end
   end

   // address/data come straight from the holding register, so they hold between accesses
   assign mem_addr  = r_hold.addr;
   assign mem_wdata = r_hold.wdata;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_hold       <= '0;
         r_last_grant <= 1'b1;
      end else if (w_hs) begin
         r_hold       <= w_hold_nxt;
         r_last_grant <= w_gnt1;
      end
   end

   assign w_rsp_rdata = (r_hold.we || r_hold.err) ? 32'h0 : mem_rdata;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_p0_rsp_vld   <= 1'b0;
         r_p0_rsp_err   <= 1'b0;
         r_p0_rsp_rdata <= 32'h0;
         r_p1_rsp_vld   <= 1'b0;
         r_p1_rsp_err   <= 1'b0;
         r_p1_rsp_rdata <= 32'h0;
      end else begin
         r_p0_rsp_vld <= 1'b0;
         r_p1_rsp_vld <= 1'b0;
         if (r_state == ACCESS) begin
            if (r_hold.port) begin
               r_p1_rsp_vld   <= 1'b1;
               r_p1_rsp_err   <= r_hold.err;
               r_p1_rsp_rdata <= w_rsp_rdata;
            end else begin
               r_p0_rsp_vld   <= 1'b1;
               r_p0_rsp_err   <= r_hold.err;
               r_p0_rsp_rdata <= w_rsp_rdata;
            end
         end
      end
   end

   assign p0_rsp_valid = r_p0_rsp_vld;
   assign p0_rsp_err   = r_p0_rsp_err;
   assign p0_rsp_rdata = r_p0_rsp_rdata;
   assign p1_rsp_valid = r_p1_rsp_vld;
   assign p1_rsp_err   = r_p1_rsp_err;
   assign p1_rsp_rdata = r_p1_rsp_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a 1024-word memory (combinational read, negedge write).
// Directed transactions with hand-computed expectations; honours DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        p0_req_valid, p0_req_ready, p0_req_we;
   logic [31:0] p0_req_addr, p0_req_wdata;
   logic        p0_rsp_valid, p0_rsp_err;
   logic [31:0] p0_rsp_rdata;
   logic        p1_req_valid, p1_req_ready, p1_req_we;
   logic [31:0] p1_req_addr, p1_req_wdata;
   logic        p1_rsp_valid, p1_rsp_err;
   logic [31:0] p1_rsp_rdata;
   logic        mem_wr_en, mem_rd_en;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] bmem [0:1023];

   int n_checks = 0;
   int n_fail   = 0;

   dmem_arbiter #(.DMEM_WORDS(1024)) dut (
      .clk          (clk),
      .reset        (reset),
      .p0_req_valid (p0_req_valid),
      .p0_req_ready (p0_req_ready),
      .p0_req_we    (p0_req_we),
      .p0_req_addr  (p0_req_addr),
      .p0_req_wdata (p0_req_wdata),
      .p0_rsp_valid (p0_rsp_valid),
      .p0_rsp_rdata (p0_rsp_rdata),
      .p0_rsp_err   (p0_rsp_err),
      .p1_req_valid (p1_req_valid),
      .p1_req_ready (p1_req_ready),
      .p1_req_we    (p1_req_we),
      .p1_req_addr  (p1_req_addr),
      .p1_req_wdata (p1_req_wdata),
      .p1_rsp_valid (p1_rsp_valid),
      .p1_rsp_rdata (p1_rsp_rdata),
      .p1_rsp_err   (p1_rsp_err),
      .mem_wr_en    (mem_wr_en),
      .mem_rd_en    (mem_rd_en),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (mem_wr_en) bmem[mem_addr[9:0]] <= mem_wdata;
   assign mem_rdata = bmem[mem_addr[9:0]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic xact(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit exp_wr, input bit exp_rd, input logic [31:0] exp_maddr,
                       input logic [31:0] exp_rdata, input bit exp_err);
      int  n;
      bit  rdy;
      if (port) begin
         p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata;
      end else begin
         p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata;
      end
      #1;
      n   = 0;
      rdy = port ? p1_req_ready : p0_req_ready;
      while (!rdy && n < 8) begin
         tick();
         rdy = port ? p1_req_ready : p0_req_ready;
         n++;
      end
      chk("req_ready", {31'h0, rdy}, 32'h1);
      tick();
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b0;
      #1;
      chk("access_wr_en", {31'h0, mem_wr_en}, {31'h0, exp_wr});
      chk("access_rd_en", {31'h0, mem_rd_en}, {31'h0, exp_rd});
      chk("access_addr", mem_addr, exp_maddr);
      if (we) chk("access_wdata", mem_wdata, wdata);
      tick();
      #1;
      chk("rsp_valid_own", {31'h0, port ? p1_rsp_valid : p0_rsp_valid}, 32'h1);
      chk("rsp_valid_other", {31'h0, port ? p0_rsp_valid : p1_rsp_valid}, 32'h0);
      chk("rsp_rdata", port ? p1_rsp_rdata : p0_rsp_rdata, exp_rdata);
      chk("rsp_err", {31'h0, port ? p1_rsp_err : p0_rsp_err}, {31'h0, exp_err});
      chk("rsp_strobes_idle", {30'h0, mem_wr_en, mem_rd_en}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp_win [0:4];
      bit e0, e1;
      logic [1:0] w;

      for (int i = 0; i < 1024; i++) bmem[i] = 32'h0;
      reset = 1'b0;
      p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 32'h0; p0_req_wdata = 32'h1111_1111;
      p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'h0; p1_req_wdata = 32'h0;

      tick();
      tick();
      chk("rst_p0_ready", {31'h0, p0_req_ready}, 32'h0);
      chk("rst_p1_ready", {31'h0, p1_req_ready}, 32'h0);
      chk("rst_strobes", {30'h0, mem_wr_en, mem_rd_en}, 32'h0);
      chk("rst_rsp_valid", {30'h0, p0_rsp_valid, p1_rsp_valid}, 32'h0);
      chk("rst_rsp_err", {30'h0, p0_rsp_err, p1_rsp_err}, 32'h0);
      chk("rst_p0_rdata", p0_rsp_rdata, 32'h0);
      chk("rst_p1_rdata", p1_rsp_rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);

      p0_req_valid = 1'b0;
      p1_req_valid = 1'b0;
      reset = 1'b1;
      tick();

      xact(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd4,     32'h0,         1'b0);
      xact(1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'd4,     32'hDEAD_BEEF, 1'b0);
      xact(1'b1, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 1'b1, 1'b0, 32'h3FF,   32'h0,         1'b0);
      xact(1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 1'b1, 32'h3FF,   32'h1234_5678, 1'b0);
      xact(1'b0, 1'b1, 32'h0000_1000, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h400,   32'h0,         1'b1);
      xact(1'b1, 1'b0, 32'h0000_0006, 32'h0,         1'b0, 1'b0, 32'h1,     32'h0,         1'b1);

      // last grant was port 1, so contention starts with port 0 in either mode
      for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
         exp_win[k] = 2'(k % 2);
`else
         exp_win[k] = 2'd0;
`endif
      end
      exp_win[4] = 2'd1;

      p0_req_we = 1'b0; p0_req_addr = 32'h0000_0010;
      p1_req_we = 1'b0; p1_req_addr = 32'h0000_0FFC;
      p0_req_valid = 1'b1;
      p1_req_valid = 1'b1;
      for (int c = 0; c <= 10; c++) begin
         if (c == 8) p0_req_valid = 1'b0;
         if (c == 9) p1_req_valid = 1'b0;
         #1;
         e0 = (c % 2 == 0) && (c <= 8) && (exp_win[c/2] == 2'd0);
         e1 = (c % 2 == 0) && (c <= 8) && (exp_win[c/2] == 2'd1);
         chk("cont_p0_ready", {31'h0, p0_req_ready}, {31'h0, e0});
         chk("cont_p1_ready", {31'h0, p1_req_ready}, {31'h0, e1});
         if (c >= 2 && c % 2 == 0) begin
            w = exp_win[c/2 - 1];
            chk("cont_p0_rsp", {31'h0, p0_rsp_valid}, {31'h0, w == 2'd0});
            chk("cont_p1_rsp", {31'h0, p1_rsp_valid}, {31'h0, w == 2'd1});
            chk("cont_rdata", (w == 2'd1) ? p1_rsp_rdata : p0_rsp_rdata,
                (w == 2'd1) ? 32'h1234_5678 : 32'hDEAD_BEEF);
         end else if (c % 2 == 1) begin
            chk("cont_no_rsp", {30'h0, p0_rsp_valid, p1_rsp_valid}, 32'h0);
         end
         tick();
      end

      // reset lands while a store sits in ACCESS
      p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 32'h0000_0020; p0_req_wdata = 32'hCAFE_F00D;
      #1;
      chk("rstacc_ready", {31'h0, p0_req_ready}, 32'h1);
      tick();
      reset = 1'b0;
      p0_req_valid = 1'b0;
      #1;
      chk("rstacc_wr_en", {31'h0, mem_wr_en}, 32'h0);
      tick();
      reset = 1'b1;
      #1;
      chk("rstacc_no_rsp", {30'h0, p0_rsp_valid, p1_rsp_valid}, 32'h0);
      chk("rstacc_hold_clr", mem_addr, 32'h0);
      chk("rstacc_mem_word", bmem[8], 32'h0);
      xact(1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 1'b1, 32'd8, 32'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
